// File: rtl/lcd_read_cycle.sv
// lcd_read_cycle
// Read-side bus-cycle generator for an HD44780-style character LCD port.
// Drives RS/RW, pulses E with programmable setup / high / recovery times,
// samples the 8-bit data bus on the edge that drops E, and optionally
// repeats status reads while the busy flag (DB7) is set.
//
// Handshake: rd_enable is a level request sampled only while state is IDLE.
// Requests seen in any other state are dropped, with no queuing. Completion
// is reported by a one-cycle rd_finish pulse, during which rd_data and
// busy_timeout are valid. rd_enable held high through rd_finish starts the
// next transaction back-to-back, because rd_finish is asserted while the FSM
// already sits in IDLE.
module lcd_read_cycle #(
   parameter int T_AS     = 2,    // address-setup cycles, RS/RW valid to E rise (>=1)
   parameter int T_EH     = 12,   // E-high cycles (>=1)
   parameter int T_EL     = 20,   // recovery cycles after E falls (>=1)
   parameter int MAX_POLL = 255   // maximum reads per busy-poll transaction (1..255)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rd_enable,
   input  logic       rs_sel,
   input  logic       poll_busy,
   input  logic [7:0] db_in,
   output logic [2:0] state,
   output logic       rd_finish,
   output logic [7:0] rd_data,
   output logic       busy_timeout,
   output logic       RS_out,
   output logic       RW_out,
   output logic       E_out,
   output logic       db_oe
);

   // ------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------
   // The phase counter must hold the largest reload value (T_x - 1).
   localparam int MAX_T01 = (T_AS > T_EH) ? T_AS : T_EH;
   localparam int MAX_T   = (MAX_T01 > T_EL) ? MAX_T01 : T_EL;
   localparam int CW      = (MAX_T <= 2) ? 1 : $clog2(MAX_T);

   localparam logic [CW-1:0] AS_LOAD  = CW'(T_AS - 1);
   localparam logic [CW-1:0] EH_LOAD  = CW'(T_EH - 1);
   localparam logic [CW-1:0] EL_LOAD  = CW'(T_EL - 1);
   localparam logic [CW-1:0] CNT_ZERO = '0;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // poll_cnt is 8 bits; MAX_POLL never exceeds 255 so it cannot wrap.
   localparam logic [7:0] POLL_LIMIT = 8'(MAX_POLL);
   localparam logic [7:0] POLL_ONE   = 8'd1;

   // FSM encoding, visible on the state output.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_EHIGH = 3'd2;
   localparam logic [2:0] ST_RECOV = 3'd3;

   // ------------------------------------------------------------------
   // Registers and next-state values
   // ------------------------------------------------------------------
   logic [2:0]    state_q,    state_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic [7:0]    poll_cnt_q, poll_cnt_d;
   logic          poll_q,     poll_d;
   logic          finish_q,   finish_d;
   logic [7:0]    data_q,     data_d;
   logic          timeout_q,  timeout_d;
   logic          rs_q,       rs_d;
   logic          rw_q,       rw_d;
   logic          e_q,        e_d;
   logic          oe_q,       oe_d;

   // Helper terms for readability in the next-state logic.
   logic cnt_done;
   logic poll_again;

   assign cnt_done   = (cnt_q == CNT_ZERO);
   // Another status read is due when polling is on, the last sample still
   // shows busy, and the poll budget is not exhausted.
   assign poll_again = poll_q & data_q[7] & (poll_cnt_q < POLL_LIMIT);

   // Next-state and output-register logic for the read sequencer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      poll_cnt_d = poll_cnt_q;
      poll_d     = poll_q;
      finish_d   = 1'b0;          // rd_finish is a single-cycle pulse
      data_d     = data_q;
      timeout_d  = timeout_q;
      rs_d       = rs_q;
      rw_d       = rw_q;
      e_d        = e_q;
      oe_d       = oe_q;

      case (state_q)
         ST_IDLE: begin
            if (rd_enable) begin
               poll_d     = poll_busy;
               rs_d       = rs_sel;
               rw_d       = 1'b1;
               oe_d       = 1'b0;      // release the bus before E can rise
               cnt_d      = AS_LOAD;
               poll_cnt_d = POLL_ONE;
               state_d    = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (!cnt_done) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               e_d     = 1'b1;
               cnt_d   = EH_LOAD;
               state_d = ST_EHIGH;
            end
         end

         ST_EHIGH: begin
            if (!cnt_done) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               // Sample on the same edge that drops E, so the data is
               // captured while the LCD is still driving it.
               data_d  = db_in;
               e_d     = 1'b0;
               cnt_d   = EL_LOAD;
               state_d = ST_RECOV;
            end
         end

         ST_RECOV: begin
            if (!cnt_done) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (poll_again) begin
               // RS/RW stay asserted across the repeated status read.
               poll_cnt_d = poll_cnt_q + POLL_ONE;
               cnt_d      = AS_LOAD;
               state_d    = ST_SETUP;
            end else begin
               rw_d      = 1'b0;
               rs_d      = 1'b0;
               oe_d      = 1'b1;
               finish_d  = 1'b1;
               timeout_d = poll_q & data_q[7];
               state_d   = ST_IDLE;
            end
         end

         default: begin
            // Unreachable encodings fall back to a quiet idle bus.
            e_d     = 1'b0;
            rw_d    = 1'b0;
            rs_d    = 1'b0;
            oe_d    = 1'b1;
            cnt_d   = CNT_ZERO;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops E and returns the bus at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= CNT_ZERO;
         poll_cnt_q <= 8'd0;
         poll_q     <= 1'b0;
         finish_q   <= 1'b0;
         data_q     <= 8'd0;
         timeout_q  <= 1'b0;
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         e_q        <= 1'b0;
         oe_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         poll_cnt_q <= poll_cnt_d;
         poll_q     <= poll_d;
         finish_q   <= finish_d;
         data_q     <= data_d;
         timeout_q  <= timeout_d;
         rs_q       <= rs_d;
         rw_q       <= rw_d;
         e_q        <= e_d;
         oe_q       <= oe_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs come straight from flops, so E never glitches.
   // ------------------------------------------------------------------
   assign state        = state_q;
   assign rd_finish    = finish_q;
   assign rd_data      = data_q;
   assign busy_timeout = timeout_q;
   assign RS_out       = rs_q;
   assign RW_out       = rw_q;
   assign E_out        = e_q;
   assign db_oe        = oe_q;

endmodule

// File: tb/tb_lcd_read_cycle.sv
// tb_lcd_read_cycle
// Directed bench for lcd_read_cycle: single reads, busy polling, poll
// timeout, ignored and back-to-back requests, and asynchronous reset.
module tb_lcd_read_cycle;

   localparam int TAS = 2;
   localparam int TEH = 12;
   localparam int TEL = 20;
   localparam int MP  = 5;
   localparam int P   = TAS + TEH + TEL;

   // ---------------- clock / reset ----------------
   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       rd_enable = 1'b0;
   logic       rs_sel    = 1'b0;
   logic       poll_busy = 1'b0;
   logic [7:0] db_in     = 8'd0;

   logic [2:0] state;
   logic       rd_finish;
   logic [7:0] rd_data;
   logic       busy_timeout;
   logic       RS_out;
   logic       RW_out;
   logic       E_out;
   logic       db_oe;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   lcd_read_cycle #(
      .T_AS(TAS), .T_EH(TEH), .T_EL(TEL), .MAX_POLL(MP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rd_enable(rd_enable), .rs_sel(rs_sel),
      .poll_busy(poll_busy), .db_in(db_in), .state(state),
      .rd_finish(rd_finish), .rd_data(rd_data), .busy_timeout(busy_timeout),
      .RS_out(RS_out), .RW_out(RW_out), .E_out(E_out), .db_oe(db_oe)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tracks position inside a transaction as an edge offset from the start
   // edge; each read occupies P edges, E is high for offsets TAS..TAS+TEH-1.
   logic       m_active;
   int         m_off;
   int         m_k;
   logic       m_poll;
   logic [2:0] e_state;
   logic       e_fin, e_to, e_rs, e_rw, e_e, e_oe;
   logic [7:0] e_data;

   always @(posedge clk or negedge rst_n) begin : model_blk
      int l;
      if (!rst_n) begin
         m_active = 1'b0; m_off = 0; m_k = 0; m_poll = 1'b0;
         e_state = 3'd0; e_fin = 1'b0; e_to = 1'b0; e_rs = 1'b0;
         e_rw = 1'b0; e_e = 1'b0; e_oe = 1'b1; e_data = 8'd0;
      end else begin
         e_fin = 1'b0;
         if (!m_active) begin
            if (rd_enable) begin
               m_active = 1'b1; m_off = 0; m_k = 0; m_poll = poll_busy;
               e_rs = rs_sel; e_rw = 1'b1; e_oe = 1'b0; e_state = 3'd1;
            end
         end else begin
            m_off++;
            l = m_off - m_k * P;
            if (l == TAS) e_e = 1'b1;
            if (l == TAS + TEH) begin
               e_e = 1'b0;
               e_data = db_in;
            end
            if (l == P) begin
               if (m_poll && e_data[7] && (m_k + 1 < MP)) begin
                  m_k++;
               end else begin
                  m_active = 1'b0; e_rw = 1'b0; e_rs = 1'b0; e_oe = 1'b1;
                  e_fin = 1'b1; e_to = m_poll & e_data[7]; e_state = 3'd0;
               end
            end
            if (m_active) begin
               l = m_off - m_k * P;
               e_state = (l < TAS) ? 3'd1 : (l < TAS + TEH) ? 3'd2 : 3'd3;
            end
         end
      end
   end

   // ---------------- compare process ----------------
   logic [7:0] prev_data = 8'd0;
   logic       prev_e    = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("state", state, e_state);
         chk("rd_finish", rd_finish, e_fin);
         chk("rd_data", rd_data, e_data);
         chk("busy_timeout", busy_timeout, e_to);
         chk("RS_out", RS_out, e_rs);
         chk("RW_out", RW_out, e_rw);
         chk("E_out", E_out, e_e);
         chk("db_oe", db_oe, e_oe);
         if (E_out) chk("db_oe_during_e", db_oe, 1'b0);
         if (E_out) chk("rw_during_e", RW_out, 1'b1);
         if (!(prev_e && !E_out)) chk("rd_data_stable", rd_data, prev_data);
      end
      prev_data = rd_data;
      prev_e    = E_out;
   end

   // ---------------- driver task ----------------
   // Starts a transaction and follows it to rd_finish. db_in shows busy_val
   // for the first n_busy reads and fin_val afterwards. inject pulses
   // rd_enable for one cycle while E is high; hold leaves rd_enable high.
   task automatic run_read(input logic rs, input logic poll, input logic [7:0] busy_val,
                           input int n_busy, input logic [7:0] fin_val,
                           input logic hold, input logic inject,
                           output int pulses, output int rise, output int fall,
                           output int fin);
      int   s;
      int   falls;
      logic pe;
      logic injected;
      pulses = 0; rise = -1; fall = -1; fin = -1; falls = 0; injected = 1'b0;
      rs_sel    = rs;
      poll_busy = poll;
      db_in     = (n_busy > 0) ? busy_val : fin_val;
      rd_enable = 1'b1;
      @(negedge clk);
      s = cyc;
      if (!hold) rd_enable = 1'b0;
      pe = E_out;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (injected && !hold) rd_enable = 1'b0;
         if (E_out && !pe) begin
            pulses++;
            if (rise < 0) rise = cyc - s;
            if (inject && !injected) begin
               rd_enable = 1'b1;
               injected  = 1'b1;
            end
         end
         if (!E_out && pe) begin
            falls++;
            if (fall < 0) fall = cyc - s;
            if (falls == n_busy) db_in = fin_val;
         end
         pe = E_out;
         if (rd_finish) begin
            fin = cyc - s;
            break;
         end
      end
      chk("finish_seen", rd_finish, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int   pulses, rise, fall, fin;
      logic fin_seen;
      logic e_before;

      #12;
      chk("rst_state", state, 3'd0);
      chk("rst_rd_finish", rd_finish, 1'b0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_busy_timeout", busy_timeout, 1'b0);
      chk("rst_RS", RS_out, 1'b0);
      chk("rst_RW", RW_out, 1'b0);
      chk("rst_E", E_out, 1'b0);
      chk("rst_db_oe", db_oe, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single data read with default timing.
      run_read(1'b1, 1'b0, 8'h00, 0, 8'hA5, 1'b0, 1'b0, pulses, rise, fall, fin);
      chk("t1_pulses", pulses, 1);
      chk("t1_rise", rise, 2);
      chk("t1_fall", fall, 14);
      chk("t1_finish", fin, 34);
      chk("t1_data", rd_data, 8'hA5);
      chk("t1_timeout", busy_timeout, 1'b0);
      repeat (3) @(negedge clk);

      // Busy poll: three busy reads, then ready.
      run_read(1'b0, 1'b1, 8'h80, 3, 8'h1F, 1'b0, 1'b0, pulses, rise, fall, fin);
      chk("t2_pulses", pulses, 4);
      chk("t2_finish", fin, 136);
      chk("t2_data", rd_data, 8'h1F);
      chk("t2_timeout", busy_timeout, 1'b0);
      repeat (3) @(negedge clk);

      // Poll timeout with DB7 stuck at 1.
      run_read(1'b0, 1'b1, 8'hFF, 99, 8'hFF, 1'b0, 1'b0, pulses, rise, fall, fin);
      chk("t3_pulses", pulses, 5);
      chk("t3_finish", fin, 170);
      chk("t3_data", rd_data, 8'hFF);
      chk("t3_timeout", busy_timeout, 1'b1);
      repeat (3) @(negedge clk);

      // Request during EHIGH is ignored; DB7=1 without polling is no timeout.
      run_read(1'b1, 1'b0, 8'h00, 0, 8'h80, 1'b0, 1'b1, pulses, rise, fall, fin);
      chk("t4_pulses", pulses, 1);
      chk("t4_finish", fin, 34);
      chk("t4_data", rd_data, 8'h80);
      chk("t4_timeout", busy_timeout, 1'b0);
      repeat (3) @(negedge clk);

      // Back-to-back: rd_enable held through rd_finish.
      run_read(1'b1, 1'b0, 8'h00, 0, 8'h3C, 1'b1, 1'b0, pulses, rise, fall, fin);
      chk("t5_finish", fin, 34);
      chk("t5_data", rd_data, 8'h3C);
      chk("t5_en_held", rd_enable, 1'b1);
      run_read(1'b0, 1'b0, 8'h00, 0, 8'hC3, 1'b0, 1'b0, pulses, rise, fall, fin);
      chk("t6_pulses", pulses, 1);
      chk("t6_rise", rise, 2);
      chk("t6_fall", fall, 14);
      chk("t6_finish", fin, 34);
      chk("t6_data", rd_data, 8'hC3);
      repeat (3) @(negedge clk);

      // Asynchronous reset while E is high.
      rs_sel = 1'b1; poll_busy = 1'b1; db_in = 8'hFF; rd_enable = 1'b1;
      @(negedge clk);
      rd_enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (E_out) break;
         @(negedge clk);
      end
      e_before = E_out;
      chk("t7_e_high", e_before, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_E_async", E_out, 1'b0);
      chk("t7_RW_async", RW_out, 1'b0);
      chk("t7_RS_async", RS_out, 1'b0);
      chk("t7_state_async", state, 3'd0);
      chk("t7_db_oe_async", db_oe, 1'b1);
      chk("t7_data_async", rd_data, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      fin_seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         fin_seen = fin_seen | rd_finish;
      end
      chk("t7_no_finish", fin_seen, 1'b0);
      chk("t7_idle", state, 3'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
